// File: rtl/connect4_pkg.sv
// Shared types and defaults for the Connect-4 move-entry front end.
package connect4_pkg;

  localparam int N_COLS_DEF = 7;
  localparam int COL_W_DEF  = 3;
  localparam int MAX_COLS   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_PEND
  } in_state_t;

  // Lowest column index whose full flag is clear; returns n_cols when every column is full.
  function automatic int first_free_col(input logic [MAX_COLS-1:0] full, input int n_cols);
    int idx;
    idx = n_cols;
    for (int i = MAX_COLS - 1; i >= 0; i--) begin
      if (i < n_cols && !full[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, stable-level debouncer, rising-edge press pulse.
// press_evt fires DEBOUNCE_CYCLES+3 clocks after a raw rise that is held steady.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every assignment to state inside always_ff is non-blocking (<=), so all
  // flops sample the pre-edge values and ordering between statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      evt_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      evt_q       <= evt_d;
      cnt_q       <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    evt_d = level_q & ~level_dly_q;
  end

  assign press_evt = evt_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Connect-4 move entry: per-player debounce, active-player filter, column check, valid/ack hold.
// Optional auto-move on idle timeout is built when TURN_TIMEOUT_EN is defined.
module player_input_ctrl
  import connect4_pkg::*;
#(
  parameter int N_PLAYERS       = 2,
  parameter int N_COLS          = N_COLS_DEF,
  parameter int COL_W           = COL_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int PID_W           = $clog2(N_PLAYERS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PLAYERS-1:0]       btn_confirm,
  input  logic [N_PLAYERS*COL_W-1:0] switches,
  input  logic [PID_W-1:0]           active_player,
  input  logic                       enable,
  input  logic [N_COLS-1:0]          col_full,
  input  logic                       move_ack,
  output logic                       valid_move,
  output logic [COL_W-1:0]           selected_col,
  output logic [PID_W-1:0]           move_player,
  output logic                       invalid_move,
  output logic                       timeout_move
);

  logic [N_PLAYERS-1:0]       press_evt;
  logic [N_PLAYERS*COL_W-1:0] sw_s1_q, sw_s2_q;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_confirm[p]),
      .press_evt(press_evt[p])
    );
  end

  // NOTE: reset is synchronous here: rst is only looked at on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= switches;
      sw_s2_q <= sw_s1_q;
    end
  end

  logic             act_evt;
  logic [COL_W-1:0] act_sw;
  logic             col_ok;

  in_state_t        state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PID_W-1:0] player_q, player_d;
  logic             tmo_q, tmo_d;
  logic             invalid_q, invalid_d;

  logic             tmo_fire;
  logic [COL_W-1:0] tmo_col;

  // Compare-based selection keeps out-of-range player ids from indexing past the arrays.
  always_comb begin
    act_evt = 1'b0;
    act_sw  = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (active_player == PID_W'(p)) begin
        act_evt = press_evt[p];
        act_sw  = sw_s2_q[p*COL_W +: COL_W];
      end
    end
    col_ok = 1'b0;
    for (int i = 0; i < N_COLS; i++) begin
      if (col_q == COL_W'(i) && !col_full[i]) col_ok = 1'b1;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;
  int               free_idx;

  always_comb begin
    free_idx = first_free_col(MAX_COLS'(col_full), N_COLS);
    tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    tmo_fire = tmo_hit && enable && (free_idx < N_COLS);
    tmo_col  = COL_W'(free_idx);
  end

  // Holds at the terminal value while every column is full so the move fires once one frees.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_IDLE && enable && state_d == S_IDLE) begin
      tmo_cnt_d = tmo_hit ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_fire   = 1'b0;
  assign tmo_col    = '0;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    player_d  = player_q;
    tmo_d     = tmo_q;
    invalid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (act_evt && enable) begin
          col_d    = act_sw;
          player_d = active_player;
          tmo_d    = 1'b0;
          state_d  = S_CHECK;
        end else if (tmo_fire) begin
          col_d    = tmo_col;
          player_d = active_player;
          tmo_d    = 1'b1;
          state_d  = S_PEND;
        end
      end
      S_CHECK: begin
        if (col_ok) begin
          state_d = S_PEND;
        end else begin
          invalid_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_PEND: begin
        // Ack wins over a simultaneous enable drop; both simply release the move.
        if (move_ack || !enable) begin
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      player_q  <= '0;
      tmo_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      player_q  <= player_d;
      tmo_q     <= tmo_d;
      invalid_q <= invalid_d;
    end
  end

  assign valid_move   = (state_q == S_PEND);
  assign selected_col = col_q;
  assign move_player  = player_q;
  assign invalid_move = invalid_q;
  assign timeout_move = tmo_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Self-checking bench for player_input_ctrl: vector table, random moves vs. rule model, corner sequences.
module tb_player_input_ctrl;

  localparam int DEB     = 4;
  localparam int TMO     = 20;
  localparam int NCOLS   = 7;
  localparam int LAT     = DEB + 5;
  localparam int N_RAND  = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_confirm;
  logic [5:0] switches;
  logic [0:0] active_player;
  logic       enable;
  logic [6:0] col_full;
  logic       move_ack;
  logic       valid_move;
  logic [2:0] selected_col;
  logic [0:0] move_player;
  logic       invalid_move;
  logic       timeout_move;

  int checks = 0;
  int errors = 0;

  player_input_ctrl #(
    .N_PLAYERS      (2),
    .N_COLS         (NCOLS),
    .COL_W          (3),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_confirm  (btn_confirm),
    .switches     (switches),
    .active_player(active_player),
    .enable       (enable),
    .col_full     (col_full),
    .move_ack     (move_ack),
    .valid_move   (valid_move),
    .selected_col (selected_col),
    .move_player  (move_player),
    .invalid_move (invalid_move),
    .timeout_move (timeout_move)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic       act;
    logic       en;
    logic       btn;
    logic [2:0] sw;
    logic [6:0] full;
    logic       exp_v;
    logic       exp_i;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Rule model: a press counts only from the active player while enabled;
  // it becomes a move if the column exists and has room, otherwise a rejection.
  function automatic void predict(input vec_t v, output logic ev, output logic ei);
    logic accepted, legal;
    accepted = (v.btn == v.act) && v.en;
    legal    = 1'b0;
    if (int'(v.sw) < NCOLS) legal = !v.full[v.sw];
    ev = accepted && legal;
    ei = accepted && !legal;
  endfunction

  task automatic wait_valid(input int max_cyc, output int cyc);
    cyc = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (valid_move) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic observe(input int n, output int vcnt, output int icnt);
    vcnt = 0;
    icnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (valid_move) vcnt++;
      if (invalid_move) icnt++;
    end
  endtask

  task automatic run_press(input vec_t v, output int vcyc, output logic [2:0] vcol,
                           output logic vply, output logic vtmo, output int icnt, output int icyc);
    vcyc = 0; vcol = '0; vply = 1'b0; vtmo = 1'b0; icnt = 0; icyc = 0;
    @(negedge clk);
    active_player = v.act;
    enable        = v.en;
    col_full      = v.full;
    switches      = 6'($urandom);
    switches[int'(v.btn)*3 +: 3] = v.sw;
    btn_confirm[v.btn] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (valid_move && vcyc == 0) begin
        vcyc = c;
        vcol = selected_col;
        vply = move_player;
        vtmo = timeout_move;
      end
      if (invalid_move) begin
        icnt++;
        icyc = c;
      end
      if (c == 10) btn_confirm = '0;
    end
    if (valid_move) begin
      move_ack = 1'b1;
      enable   = 1'b0;
      @(negedge clk);
      check("ack_clear", valid_move, 0);
      move_ack = 1'b0;
    end else begin
      enable = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic apply_vec(input string name, input vec_t v, input logic ev, input logic ei);
    int vcyc, icnt, icyc;
    logic [2:0] vcol;
    logic vply, vtmo;
    run_press(v, vcyc, vcol, vply, vtmo, icnt, icyc);
    check({name, "_vlat"}, vcyc, ev ? LAT : 0);
    if (ev) begin
      check({name, "_col"}, vcol, v.sw);
      check({name, "_ply"}, vply, v.act);
      check({name, "_tmo"}, vtmo, 0);
    end
    check({name, "_inv_cnt"}, icnt, ei ? 1 : 0);
    if (ei) check({name, "_inv_cyc"}, icyc, LAT);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, valid_move, 0);
    check({name, "_col"}, selected_col, 0);
    check({name, "_ply"}, move_player, 0);
    check({name, "_inv"}, invalid_move, 0);
    check({name, "_tmo"}, timeout_move, 0);
  endtask

  initial begin
    int   cyc, vc, ic;
    logic ev, ei;
    vec_t v;

    rst = 1'b1; btn_confirm = '0; switches = '0; active_player = '0;
    enable = 1'b0; col_full = '0; move_ack = 1'b0;

    //             act   en    btn   sw    full          exp_v exp_i
    tbl[0] = '{1'b0, 1'b1, 1'b0, 3'd4, 7'b0000000, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 3'd2, 7'b0000000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 3'd7, 7'b0000000, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 3'd3, 7'b0001000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 3'd6, 7'b0111111, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 3'd1, 7'b0000000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 3'd0, 7'b1111110, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 3'd0, 7'b0000001, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) apply_vec($sformatf("tbl%0d", i), tbl[i], tbl[i].exp_v, tbl[i].exp_i);

    for (int i = 0; i < N_RAND; i++) begin
      v.act  = 1'($urandom);
      v.btn  = ($urandom_range(3) == 0) ? ~v.act : v.act;
      v.en   = ($urandom_range(4) != 0);
      v.sw   = 3'($urandom);
      v.full = 7'($urandom) & 7'($urandom);
      predict(v, ev, ei);
      apply_vec($sformatf("rnd%0d", i), v, ev, ei);
    end

    // Pending move stays frozen through a new press and a player change, then acks cleanly.
    @(negedge clk);
    active_player = 1'b0; enable = 1'b1; col_full = '0;
    switches = 6'b000_101; btn_confirm = 2'b01;
    wait_valid(20, cyc);
    check("hold_lat", cyc, LAT);
    check("hold_col", selected_col, 5);
    check("hold_ply", move_player, 0);
    @(negedge clk);
    btn_confirm = '0; active_player = 1'b1;
    repeat (7) @(negedge clk);
    btn_confirm = 2'b01; switches = 6'b000_001;
    repeat (12) @(negedge clk);
    check("hold_valid", valid_move, 1);
    check("hold_col_frozen", selected_col, 5);
    check("hold_ply_frozen", move_player, 0);
    check("hold_no_inv", invalid_move, 0);
    move_ack = 1'b1; active_player = 1'b0;
    @(negedge clk);
    check("hold_ack_drop", valid_move, 0);
    move_ack = 1'b0; btn_confirm = '0;
    observe(12, vc, ic);
    check("hold_no_stale_valid", vc, 0);
    check("hold_no_stale_inv", ic, 0);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    // Enable drop in pending state aborts without an invalid pulse.
    active_player = 1'b1; enable = 1'b1; col_full = '0;
    switches = 6'b011_000; btn_confirm = 2'b10;
    wait_valid(20, cyc);
    check("abort_lat", cyc, LAT);
    check("abort_ply", move_player, 1);
    @(negedge clk);
    btn_confirm = '0; enable = 1'b0;
    @(negedge clk);
    check("abort_drop", valid_move, 0);
    observe(10, vc, ic);
    check("abort_no_valid", vc, 0);
    check("abort_no_inv", ic, 0);

    // Two short bounces never reach the debounce threshold.
    active_player = 1'b0; enable = 1'b1; col_full = '0; switches = 6'b000_010;
    btn_confirm = 2'b01; repeat (2) @(negedge clk);
    btn_confirm = 2'b00; repeat (2) @(negedge clk);
    btn_confirm = 2'b01; repeat (2) @(negedge clk);
    btn_confirm = 2'b00;
    observe(10, vc, ic);
    check("bounce_no_valid", vc, 0);
    check("bounce_no_inv", ic, 0);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    v = '{1'b0, 1'b1, 1'b0, 3'd2, 7'b0000000, 1'b1, 1'b0};
    apply_vec("bounce_stable", v, 1'b1, 1'b0);

    // Reset while the column is being checked clears everything.
    @(negedge clk);
    active_player = 1'b0; enable = 1'b1; col_full = '0;
    switches = 6'b000_100; btn_confirm = 2'b01;
    repeat (LAT - 1) @(negedge clk);
    check("rst_pre_valid", valid_move, 0);
    rst = 1'b1; btn_confirm = '0;
    @(negedge clk);
    check_all_zero("rst_check");
    rst = 1'b0;
    observe(12, vc, ic);
    check("rst_no_valid", vc, 0);
    check("rst_no_inv", ic, 0);
    enable = 1'b0;
    repeat (4) @(negedge clk);

`ifdef TURN_TIMEOUT_EN
    // Idle timeout picks the lowest free column.
    active_player = 1'b0; col_full = 7'b0000011; enable = 1'b1;
    wait_valid(TMO + 10, cyc);
    check("tmo_lat", cyc, TMO);
    check("tmo_col", selected_col, 2);
    check("tmo_flag", timeout_move, 1);
    check("tmo_ply", move_player, 0);
    move_ack = 1'b1; enable = 1'b0;
    @(negedge clk);
    move_ack = 1'b0;
    check("tmo_ack", valid_move, 0);
    col_full = 7'b1111111; enable = 1'b1;
    observe(TMO + 10, vc, ic);
    check("tmo_full_no_move", vc, 0);
    col_full = 7'b1011111;
    wait_valid(3, cyc);
    check("tmo_free_lat", cyc, 1);
    check("tmo_free_col", selected_col, 5);
    move_ack = 1'b1; enable = 1'b0;
    @(negedge clk);
    move_ack = 1'b0;
`else
    check("no_tmo_flag", timeout_move, 0);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
